scadere_secventiala: RTL and testbench

//   Multi-cycle 16-bit subtractor: d = x - y - b0, one 4-bit slice per clock, LSB slice first.

---
 rtl/scadere_pkg.sv | 15 +
 rtl/scadere_secventiala_scade4.sv | 19 +
 rtl/scadere_secventiala.sv | 124 ++++++++++++
 tb/tb_scadere_secventiala.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/scadere_pkg.sv
// Shared defaults and FSM encoding for the slice-serial subtractor.
package scadere_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_SLICE  = 4;
  localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

  // 2'd3 is unreachable; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scadere_secventiala_scade4.sv
// Combinational narrow subtract slice: diff = a - b - bin, bout = 1 when a < b + bin.
module scade4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] res;

  // The extra top bit goes to 1 exactly when the slice result is negative.
  assign res  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign diff = res[W-1:0];
  assign bout = res[W];

endmodule

// File: rtl/scadere_secventiala.sv
// Slice-serial subtractor: d = x - y - b0, one SLICE-wide chunk per clock, LSB chunk first.
module scadere_secventiala
  import scadere_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   xop_q, xop_d;
  logic [WIDTH-1:0]   yop_q, yop_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   sl_a, sl_b, sl_diff;
  logic               sl_bout;
  logic [WIDTH-1:0]   work_nxt;

  assign sl_a = xop_q[idx_q*SLICE +: SLICE];
  assign sl_b = yop_q[idx_q*SLICE +: SLICE];

  scade4 #(.W(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (borrow_q),
    .diff (sl_diff),
    .bout (sl_bout)
  );

  // Work value with the current slice merged in, so the completing edge sees the full result.
  always_comb begin
    work_nxt = work_q;
    work_nxt[idx_q*SLICE +: SLICE] = sl_diff;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    xop_d    = xop_q;
    yop_d    = yop_q;
    work_d   = work_q;
    d_d      = d_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_RUN: begin
        work_d   = work_nxt;
        borrow_d = sl_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          idx_d   = '0;
          d_d     = work_nxt;
          bout_d  = sl_bout;
          ovf_d   = (xop_q[WIDTH-1] != yop_q[WIDTH-1]) &&
                    (work_nxt[WIDTH-1] != xop_q[WIDTH-1]);
        end
      end
      default: begin
        // IDLE, DONE and the unused code all accept a new request here.
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          xop_d    = x;
          yop_d    = y;
          borrow_d = b0;
          idx_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      xop_q    <= '0;
      yop_q    <= '0;
      work_q   <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      xop_q    <= xop_d;
      yop_q    <= yop_d;
      work_q   <= work_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign d     = d_q;
  assign b_out = bout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_scadere_secventiala.sv
// Self-checking bench for scadere_secventiala against a whole-word arithmetic model.
module tb_scadere_secventiala;

  logic        clk, rst, start, b0;
  logic [15:0] x, y;
  logic        busy, done, b_out, ovf;
  logic [15:0] d;

  int checks = 0;
  int errors = 0;

  // Outputs the DUT is expected to hold until its next completion.
  logic [15:0] last_d;
  logic        last_bout, last_ovf;

  scadere_secventiala dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .b0(b0),
    .busy(busy), .done(done), .d(d), .b_out(b_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; called #1 after an edge (or mid-cycle). Edge count includes the accept edge.
  task automatic run_op(input logic [15:0] ax, input logic [15:0] ay, input logic ab,
                        input bit disturb, input string tag);
    logic [16:0] r;
    logic        eov;
    int          n;
    r   = {1'b0, ax} - {1'b0, ay} - {16'd0, ab};
    eov = (ax[15] != ay[15]) && (r[15] != ax[15]);
    x = ax; y = ay; b0 = ab; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run_flags busy=%b done=%b required busy=1 done=0 edge=%0d", tag, busy, done, n);
      end
      checks++;
      if (d !== last_d || b_out !== last_bout || ovf !== last_ovf) begin
        errors++;
        $display("FAIL %s hold d=%h b=%b o=%b required d=%h b=%b o=%b", tag, d, b_out, ovf,
                 last_d, last_bout, last_ovf);
      end
      if (disturb && n == 2) begin
        start = 1'b1; x = 16'($urandom); y = 16'($urandom); b0 = ~ab;
      end else if (disturb && n == 3) begin
        start = 1'b0; x = ~ax; y = ~ay;
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL %s latency got %0d edges required 5", tag, n);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags busy=%b done=%b required busy=0 done=1", tag, busy, done);
    end
    checks++;
    if (d !== r[15:0] || b_out !== r[16] || ovf !== eov) begin
      errors++;
      $display("FAIL %s result x=%h y=%h b0=%b got d=%h b=%b o=%b required d=%h b=%b o=%b",
               tag, ax, ay, ab, d, b_out, ovf, r[15:0], r[16], eov);
    end
    last_d = r[15:0]; last_bout = r[16]; last_ovf = eov;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; b0 = 1'b0;
    last_d = '0; last_bout = 1'b0; last_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || d !== 0 || b_out !== 0 || ovf !== 0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b d=%h b=%b o=%b required all zero", busy, done, d, b_out, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    run_op(16'h1234, 16'h0234, 1'b0, 0, "d_1234");
    run_op(16'h0000, 16'h0001, 1'b0, 0, "d_ripple");
    run_op(16'h8000, 16'h0001, 1'b0, 0, "d_ovf_neg");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, "d_ovf_pos");
    run_op(16'h0005, 16'h0005, 1'b1, 0, "d_bin");
    run_op(16'h1000, 16'h0001, 1'b0, 0, "d_1000");
  endtask

  task automatic test_done_pulse;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL done_pulse busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (d !== last_d) begin
      errors++;
      $display("FAIL idle_hold d=%h required %h", d, last_d);
    end
  endtask

  task automatic test_ignore_start;
    run_op(16'hA5C3, 16'h3C5A, 1'b1, 1, "ignore_start");
    run_op(16'h0F0F, 16'hF0F0, 1'b0, 1, "ignore_start2");
  endtask

  task automatic test_back_to_back;
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, "b2b_a");
    run_op(16'h4321, 16'h1234, 1'b0, 0, "b2b_b");
    run_op(16'h0001, 16'h8000, 1'b1, 0, "b2b_c");
  endtask

  task automatic test_reset_mid;
    run_op(16'h1234, 16'h0234, 1'b0, 0, "pre_rst");
    x = 16'h5555; y = 16'h1111; b0 = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || d !== 0 || b_out !== 0 || ovf !== 0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b d=%h b=%b o=%b required all zero", busy, done, d, b_out, ovf);
    end
    last_d = '0; last_bout = 1'b0; last_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 0 || busy !== 0) begin
        errors++;
        $display("FAIL reset_mid_nodone busy=%b done=%b required 0 0", busy, done);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h5555, 16'h1111, 1'b0, 0, "post_rst");
  endtask

  task automatic test_random;
    for (int i = 0; i < 10000; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 0, "rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_done_pulse();
    test_ignore_start();
    test_back_to_back();
    test_done_pulse();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
